// File: rtl/frame_pkg.sv
// Shared frame geometry and capture FSM state encoding for the video datapath blocks.
package frame_pkg;

  localparam int DEF_W      = 30;
  localparam int DEF_WIDTH  = 320;
  localparam int DEF_HEIGHT = 240;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with first-word-fall-through output; push and pop may coincide when full.
module skid_fifo2 #(
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'd2);
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/stream_frame_writer.sv
// Captures one raster frame from a valid/ready pixel stream and writes it linearly into a frame buffer.
module stream_frame_writer
  import frame_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [W-1:0]                      x_data,
  input  logic                              x_valid,
  output logic                              x_ready,
  input  logic                              start,
  input  logic                              continuous,
  input  logic                              mem_ready,
  output logic                              wr_en,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   wr_addr,
  output logic [W-1:0]                      wr_data,
  output logic                              frame_done,
  output logic                              busy
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  fsm_state_e   state_q;
  logic [AW-1:0] acc_cnt_q;
  logic [AW-1:0] wr_cnt_q;
  logic          frame_done_q;
  logic          rearm_q;

  logic          fifo_empty;
  logic          fifo_full;
  logic [W-1:0]  fifo_dout;
  logic          accept;
  logic          last_wr;

  // The accept counter stops at the last pixel; leaving ACTIVE is what closes the input.
  assign x_ready    = (state_q == ST_ACTIVE) && !fifo_full && !reset;
  assign accept     = x_valid && x_ready;
  assign wr_en      = !fifo_empty && mem_ready && !reset;
  assign wr_addr    = wr_cnt_q;
  assign wr_data    = fifo_dout;
  assign last_wr    = wr_en && (wr_cnt_q == LAST);
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

  skid_fifo2 #(.W(W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (wr_en),
    .din   (x_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      acc_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      frame_done_q <= 1'b0;
      rearm_q      <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (wr_en && !last_wr) wr_cnt_q <= wr_cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (accept) begin
            if (acc_cnt_q == LAST) state_q <= ST_DRAIN;
            else                   acc_cnt_q <= acc_cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          // A start seen anywhere in DRAIN arms the next frame.
          if (start) rearm_q <= 1'b1;
          if (last_wr) begin
            frame_done_q <= 1'b1;
            acc_cnt_q    <= '0;
            wr_cnt_q     <= '0;
            rearm_q      <= 1'b0;
            state_q      <= (continuous || start || rearm_q) ? ST_ACTIVE : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
